led_sequencer: RTL
==================

# led_sequencer

Parametrised multi-channel LED pattern generator for the board-level indicator LEDs, driven directly from the system clock. It generalises the fixed 3-LED rotate-every-half-second blinker to N LEDs with four selectable modes: rotate, bounce, blink-all and PWM breathe. It also adds a pause control and configurable output polarity. It sits at the top level between `sys_clk`/`sys_rst` and the LED pins; no other logic is required.

## Interface
- `TICK_CYCLES`, 12_000_000 — pattern step period in `sys_clk` cycles (0.5 s at 24 MHz); must be ≥ 2.
- `STEP_CYCLES`, 46_875 — breathe duty-step period in cycles; must be ≥ 2. The default gives ≈1 s for a full up+down ramp at PWM_BITS=8.
- `N_LED`, 3 — number of LEDs; must be ≥ 2.
- `PWM_BITS`, 8 — breathe PWM resolution.
- `ACTIVE_LOW`, 1 — 1: a lit LED drives 0 on its pin; 0: a lit LED drives 1.

Ports:
- `sys_clk`  in  1  system clock, 24 MHz.
- `sys_rst`  in  1  reset; **one clock; reset is asynchronous and active-high**.
- `mode`  in  2  pattern select: 0 rotate, 1 bounce, 2 blink-all, 3 breathe. Synchronous to `sys_clk`.
- `pause`  in  1  1 = freeze pattern timing.
- `led`  out  N_LED  LED pins; registered output, polarity per `ACTIVE_LOW`.

## Operation
Internal state:
- `pat[N_LED-1:0]`: 1 = LED lit.
- `dir`: bounce direction.
- `duty[PWM_BITS-1:0]` and `bdir`: breathe level and ramp direction.
- `mode_q`: registered copy of `mode`.
- `tick_cnt` and `step_cnt`: prescalers, each `$clog2` of its period wide, minimum 1 bit.
- `pwm_cnt[PWM_BITS-1:0]`: free-running PWM counter.

Prescalers:
- `tick` is asserted when `tick_cnt == TICK_CYCLES-1`; `tick_cnt` then wraps to 0.
- `step` is defined the same way from `step_cnt` and STEP_CYCLES.
- Both counters hold while `pause=1`, so no tick or step fires during pause.
- `pwm_cnt` increments every cycle, wraps from 2^PWM_BITS-1 to 0, and ignores `pause`.

Reset values (all applied asynchronously):
- `pat` = one-hot LED0 (…001).
- `dir` = up; `bdir` = up.
- `duty` = 0.
- All counters = 0.
- `mode_q` = 0.
- `led` = `ACTIVE_LOW ? ~{…001} : {…001}`; for N_LED=3, active-low, this is 3'b110.

Mode behaviour (state changes only on `tick`, or on `step` for breathe):
- **Rotate (0):** `pat <= {pat[N-2:0], pat[N-1]}`.
- **Bounce (1):** the one-hot position moves toward the MSB while `dir` is up.
  - A tick taken while `pat[N-1]` is set and `dir` is up sets `dir` to down and shifts right.
  - The mirror rule applies at LED0.
  - Ends are not repeated: for N=3 the sequence is 001,010,100,010,001,…
- **Blink (2):** `pat <= (pat == all-ones) ? 0 : all-ones`.
- **Breathe (3):** on each `step`:
  - `duty` moves ±1 according to `bdir`.
  - At `duty == 2^PWM_BITS-1` with `bdir` up: flip to down and decrement.
  - At `duty == 0` with `bdir` down: flip to up and increment.
  - All LEDs are lit when `pwm_cnt < duty`. Duty 0 = always off; maximum duty = lit for (2^PWM_BITS-1) of every 2^PWM_BITS cycles.

Mode change:
- When `mode != mode_q`, the next edge sets `mode_q <= mode` and reloads state:
  - rotate/bounce: `pat` = …001, `dir` = up.
  - blink: `pat` = all-ones.
  - breathe: `duty` = 0, `bdir` = up.
  - Both prescalers = 0.
- The reload has priority over a coincident `tick`/`step` (that tick is discarded).
- Reload happens even while `pause=1`.

Output: `led` is registered from the next-state lit vector, with inversion if `ACTIVE_LOW`.

## Timing
- `led` updates on the same edge that updates `pat` or `duty`; there is no extra pipeline stage.
- Breathe output follows `pwm_cnt` with 1-cycle latency.
- After reset release, the first rotate/bounce/blink change occurs at the TICK_CYCLES-th rising edge. Later changes occur exactly every TICK_CYCLES cycles.
- Pause for P cycles delays every subsequent transition by exactly P cycles. The partial period is preserved, not restarted.
- Mode change: `led` shows the reload pattern one edge after `mode` changes. The next pattern change comes TICK_CYCLES edges after that edge.
- Reset asserted mid-sequence forces `led` to its reset value immediately, without waiting for a clock edge.

## Test plan
Bench parameters: TICK_CYCLES=4, STEP_CYCLES=2, N_LED=3, PWM_BITS=2, ACTIVE_LOW=1.

1. Reset, then release with `mode`=0 → `led` = 110 during reset, then 101 at edge 4, 011 at edge 8, 110 at edge 12.
2. `mode`=1 from reset → `led` sequence 110,101,011,101,110,101, changing every 4 cycles.
3. Switch `mode` 0→2 on the same cycle that `tick` is asserted → next edge `led` = 000 (all lit; the tick is discarded); 111 four cycles later; alternating thereafter.
4. `mode`=3 → `duty` sequence 0,1,2,3,2,1,0,1, changing every 2 cycles. With `duty` held at 2 under `pause`, each 4-cycle PWM window shows `led` = 000 for 2 cycles and 111 for 2 cycles.
5. Rotate mode with `pause`=1 for 10 cycles at cycle 2 of a period → the next transition lands 10 cycles later than nominal; spacing stays at 4 cycles thereafter.
6. Assert `sys_rst` between clock edges mid-bounce → `led` = 110 immediately. After release, the sequence restarts from LED0 with `dir` up.

Source files
------------

// File: rtl/led_sequencer.sv
// Multi-channel LED pattern generator: rotate, bounce, blink-all and PWM breathe,
// with pause control and selectable output polarity.
module led_sequencer #(
   parameter int unsigned TICK_CYCLES = 12_000_000,
   parameter int unsigned STEP_CYCLES = 46_875,
   parameter int unsigned N_LED       = 3,
   parameter int unsigned PWM_BITS    = 8,
   parameter int unsigned ACTIVE_LOW  = 1
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic [1:0]       mode,
   input  logic             pause,
   output logic [N_LED-1:0] led
);

   localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

   localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_CYCLES - 1);
   localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);
   localparam logic [N_LED-1:0]    PAT_INIT  = {{(N_LED-1){1'b0}}, 1'b1};
   localparam logic [N_LED-1:0]    PAT_ALL   = '1;
   localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
   localparam logic [N_LED-1:0]    LED_RST   = (ACTIVE_LOW != 0) ? ~PAT_INIT : PAT_INIT;

   typedef enum logic [1:0] {
      MODE_ROTATE  = 2'd0,
      MODE_BOUNCE  = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   mode_e               mode_q, mode_d;
   dir_e                dir_q, dir_d;
   dir_e                bdir_q, bdir_d;
   logic [N_LED-1:0]    pat_q, pat_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [N_LED-1:0]    led_q, led_d;
   logic [N_LED-1:0]    lit;
   logic                tick;
   logic                step;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         mode_q     <= MODE_ROTATE;
         dir_q      <= DIR_UP;
         bdir_q     <= DIR_UP;
         pat_q      <= PAT_INIT;
         duty_q     <= '0;
         tick_cnt_q <= '0;
         step_cnt_q <= '0;
         pwm_cnt_q  <= '0;
         led_q      <= LED_RST;
      end else begin
         mode_q     <= mode_d;
         dir_q      <= dir_d;
         bdir_q     <= bdir_d;
         pat_q      <= pat_d;
         duty_q     <= duty_d;
         tick_cnt_q <= tick_cnt_d;
         step_cnt_q <= step_cnt_d;
         pwm_cnt_q  <= pwm_cnt_d;
         led_q      <= led_d;
      end
   end

   always_comb begin
      mode_d     = mode_q;
      dir_d      = dir_q;
      bdir_d     = bdir_q;
      pat_d      = pat_q;
      duty_d     = duty_q;
      tick_cnt_d = tick_cnt_q;
      step_cnt_d = step_cnt_q;
      pwm_cnt_d  = pwm_cnt_q + 1'b1;
      tick       = 1'b0;
      step       = 1'b0;

      // A mode change reloads state and restarts both prescalers, discarding any coincident tick/step.
      if (mode_e'(mode) != mode_q) begin
         mode_d     = mode_e'(mode);
         tick_cnt_d = '0;
         step_cnt_d = '0;
         case (mode_e'(mode))
            MODE_ROTATE, MODE_BOUNCE: begin
               pat_d = PAT_INIT;
               dir_d = DIR_UP;
            end
            MODE_BLINK: pat_d = PAT_ALL;
            default: begin
               duty_d = '0;
               bdir_d = DIR_UP;
            end
         endcase
      end else if (!pause) begin
         tick       = (tick_cnt_q == TICK_LAST);
         step       = (step_cnt_q == STEP_LAST);
         tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
         step_cnt_d = step ? '0 : step_cnt_q + 1'b1;

         if (tick) begin
            case (mode_q)
               MODE_ROTATE: pat_d = {pat_q[N_LED-2:0], pat_q[N_LED-1]};
               MODE_BOUNCE: begin
                  if (dir_q == DIR_UP) begin
                     if (pat_q[N_LED-1]) begin
                        dir_d = DIR_DOWN;
                        pat_d = {1'b0, pat_q[N_LED-1:1]};
                     end else begin
                        pat_d = {pat_q[N_LED-2:0], 1'b0};
                     end
                  end else begin
                     if (pat_q[0]) begin
                        dir_d = DIR_UP;
                        pat_d = {pat_q[N_LED-2:0], 1'b0};
                     end else begin
                        pat_d = {1'b0, pat_q[N_LED-1:1]};
                     end
                  end
               end
               MODE_BLINK: pat_d = (pat_q == PAT_ALL) ? '0 : PAT_ALL;
               default: ;
            endcase
         end

         if (step && (mode_q == MODE_BREATHE)) begin
            if (bdir_q == DIR_UP) begin
               if (duty_q == DUTY_MAX) begin
                  bdir_d = DIR_DOWN;
                  duty_d = duty_q - 1'b1;
               end else begin
                  duty_d = duty_q + 1'b1;
               end
            end else begin
               if (duty_q == '0) begin
                  bdir_d = DIR_UP;
                  duty_d = duty_q + 1'b1;
               end else begin
                  duty_d = duty_q - 1'b1;
               end
            end
         end
      end

      // Output is taken from next-state values so it changes on the same edge as the pattern.
      lit   = (mode_d == MODE_BREATHE) ? {N_LED{pwm_cnt_q < duty_d}} : pat_d;
      led_d = (ACTIVE_LOW != 0) ? ~lit : lit;
   end

   assign led = led_q;

endmodule
